// File: rtl/gpio_pkg.sv
// Register map and shared helpers for the memory-mapped GPIO peripheral.
// Offsets are word indices taken from address_in[5:2].
package gpio_pkg;

    localparam logic [3:0] GPIO_OUT     = 4'h0;
    localparam logic [3:0] GPIO_DIR     = 4'h1;
    localparam logic [3:0] GPIO_IN      = 4'h2;
    localparam logic [3:0] GPIO_SET     = 4'h3;
    localparam logic [3:0] GPIO_CLR     = 4'h4;
    localparam logic [3:0] GPIO_TGL     = 4'h5;
    localparam logic [3:0] GPIO_RISE_EN = 4'h6;
    localparam logic [3:0] GPIO_FALL_EN = 4'h7;
    localparam logic [3:0] GPIO_PENDING = 4'h8;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-wide, STAGES-deep synchroniser chain for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_out = chain_q[STAGES-1];

endmodule

// File: rtl/gpio.sv
// GPIO peripheral: per-pin direction, atomic set/clear/toggle, synchronised
// input and rise/fall edge interrupts latched in a write-1-to-clear register.
module gpio #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq_out,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in
);
    import gpio_pkg::*;

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pending_q, pending_d, prev_q, prev_d;
    logic [WIDTH-1:0] sync_s, wr_bits, wr_val, w1c, rise, fall;
    logic [31:0]      lane_bits, val_masked;
    logic [3:0]       offset;
    logic             wr_en;
    logic             unused_bus;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (pins_in),
        .q_out (sync_s)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_bits[8*gi +: 8] = {8{write_mask_in[gi]}};
    end

    assign offset     = address_in[5:2];
    assign wr_en      = sel_in && (write_mask_in != 4'b0000);
    assign val_masked = write_value_in & lane_bits;
    assign wr_bits    = lane_bits[WIDTH-1:0];
    assign wr_val     = val_masked[WIDTH-1:0];
    assign rise       = sync_s & ~prev_q;
    assign fall       = ~sync_s & prev_q;
    // Reads have no side effects and bits above WIDTH are discarded.
    assign unused_bus = ^{address_in[31:6], address_in[1:0], read_in, val_masked, lane_bits};

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        prev_d    = sync_s;
        w1c       = '0;
        if (wr_en) begin
            case (offset)
                GPIO_OUT:     out_d     = (out_q & ~wr_bits) | wr_val;
                GPIO_DIR:     dir_d     = (dir_q & ~wr_bits) | wr_val;
                GPIO_SET:     out_d     = out_q | wr_val;
                GPIO_CLR:     out_d     = out_q & ~wr_val;
                GPIO_TGL:     out_d     = out_q ^ wr_val;
                GPIO_RISE_EN: rise_en_d = (rise_en_q & ~wr_bits) | wr_val;
                GPIO_FALL_EN: fall_en_d = (fall_en_q & ~wr_bits) | wr_val;
                GPIO_PENDING: w1c       = wr_val;
                default:      ;
            endcase
        end
        // New events are ORed in after the clear so a same-cycle edge survives W1C.
        pending_d = (pending_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= OUT_RESET;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            prev_q    <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            prev_q    <= prev_d;
        end
    end

    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (offset)
                GPIO_OUT:     read_value_out[WIDTH-1:0] = out_q;
                GPIO_DIR:     read_value_out[WIDTH-1:0] = dir_q;
                GPIO_IN:      read_value_out[WIDTH-1:0] = sync_s;
                GPIO_RISE_EN: read_value_out[WIDTH-1:0] = rise_en_q;
                GPIO_FALL_EN: read_value_out[WIDTH-1:0] = fall_en_q;
                GPIO_PENDING: read_value_out[WIDTH-1:0] = pending_q;
                default:      ;
            endcase
        end
    end

    assign pins_out = out_q;
    assign pins_oe  = dir_q;
    assign irq_out  = |pending_q;

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench for gpio: directed scenarios plus randomized bus/pin
// traffic compared against a register-level behavioural model.
module tb_gpio;

    localparam int         SYNC  = 2;
    localparam logic [7:0] OUT_R = 8'h3C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pins_in = '0;
    logic [11:0] pins12_in = '0;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;

    logic [7:0]  out8, oe8;
    logic        irq8;
    logic [31:0] rd8;
    logic [11:0] out12, oe12;
    logic        irq12;
    logic [31:0] rd12;

    int n_checks = 0;
    int n_fail = 0;

    gpio #(.WIDTH(8), .SYNC_STAGES(SYNC), .OUT_RESET(OUT_R)) dut (
        .clk(clk), .reset(reset), .pins_in(pins_in), .pins_out(out8), .pins_oe(oe8),
        .irq_out(irq8), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
        .read_value_out(rd8), .write_mask_in(write_mask_in), .write_value_in(write_value_in)
    );

    gpio #(.WIDTH(12), .SYNC_STAGES(SYNC), .OUT_RESET(12'h000)) dut12 (
        .clk(clk), .reset(reset), .pins_in(pins12_in), .pins_out(out12), .pins_oe(oe12),
        .irq_out(irq12), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
        .read_value_out(rd12), .write_mask_in(write_mask_in), .write_value_in(write_value_in)
    );

    always #5 clk = ~clk;

    // Behavioural model of the 8-bit instance.
    logic [7:0] m_out, m_dir, m_rise, m_fall, m_pend;
    logic [7:0] hist [0:SYNC];   // hist[i] = pin sample taken i+1 edges ago

    task automatic m_reset();
        m_out  = OUT_R;
        m_dir  = '0;
        m_rise = '0;
        m_fall = '0;
        m_pend = '0;
        for (int i = 0; i <= SYNC; i++) hist[i] = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] off);
        logic [31:0] r;
        r = '0;
        case (off)
            4'h0: r[7:0] = m_out;
            4'h1: r[7:0] = m_dir;
            4'h2: r[7:0] = hist[SYNC-1];
            4'h6: r[7:0] = m_rise;
            4'h7: r[7:0] = m_fall;
            4'h8: r[7:0] = m_pend;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Advance one clock edge, updating the model from the inputs present at it.
    task automatic tick();
        logic [7:0] lanes, v, ev, w1c, s, p;
        lanes = {8{write_mask_in[0]}};
        v     = write_value_in[7:0] & lanes;
        s     = hist[SYNC-1];
        p     = hist[SYNC];
        ev    = (s & ~p & m_rise) | (~s & p & m_fall);
        w1c   = '0;
        if (sel_in && write_mask_in != 4'b0 && !reset) begin
            case (address_in[5:2])
                4'h0: m_out  = (m_out & ~lanes) | v;
                4'h1: m_dir  = (m_dir & ~lanes) | v;
                4'h3: m_out  = m_out | v;
                4'h4: m_out  = m_out & ~v;
                4'h5: m_out  = m_out ^ v;
                4'h6: m_rise = (m_rise & ~lanes) | v;
                4'h7: m_fall = (m_fall & ~lanes) | v;
                4'h8: w1c    = v;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~w1c) | ev;
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pins_in;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] val, input logic [3:0] mask);
        address_in     = {26'h0, off, 2'b00};
        sel_in         = 1'b1;
        read_in        = 1'b0;
        write_mask_in  = mask;
        write_value_in = val;
        $display("wr  off=%h val=%h mask=%b", off, val, mask);
        tick();
        sel_in        = 1'b0;
        write_mask_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] d8, output logic [31:0] d12);
        address_in    = {26'h0, off, 2'b00};
        sel_in        = 1'b1;
        read_in       = 1'b1;
        write_mask_in = '0;
        #1;
        d8  = rd8;
        d12 = rd12;
        sel_in  = 1'b0;
        read_in = 1'b0;
        $display("rd  off=%h data=%h", off, d8);
    endtask

    task automatic test_reset();
        logic [31:0] d, d12;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        bus_read(4'h0, d, d12);
        n_checks++;
        if (d !== 32'h0000_003C) begin n_fail++; $display("FAIL reset_out got=%h exp=%h", d, 32'h3C); end
        bus_read(4'h1, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_dir got=%h exp=0", d); end
        n_checks++;
        if (irq8 !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq8); end
        n_checks++;
        if (out8 !== OUT_R || oe8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_pins out=%h oe=%h exp out=%h oe=00", out8, oe8, OUT_R);
        end
        address_in = 32'h0;
        sel_in = 1'b0;
        #1;
        n_checks++;
        if (rd8 !== 32'h0) begin n_fail++; $display("FAIL unsel_read got=%h exp=0", rd8); end
    endtask

    task automatic test_set_clr_tgl();
        logic [31:0] d, d12;
        bus_write(4'h0, 32'h0000_00A5, 4'b1111);
        bus_write(4'h3, 32'h0000_000F, 4'b1111);
        bus_write(4'h4, 32'h0000_0080, 4'b1111);
        bus_write(4'h5, 32'h0000_0003, 4'b1111);
        bus_read(4'h0, d, d12);
        n_checks++;
        if (d !== 32'h0000_002C) begin n_fail++; $display("FAIL out_atomic got=%h exp=%h", d, 32'h2C); end
        n_checks++;
        if (out8 !== 8'h2C) begin n_fail++; $display("FAIL pins_out got=%h exp=2c", out8); end
        bus_write(4'h0, 32'hFFFF_FF00, 4'b1110);
        bus_read(4'h0, d, d12);
        n_checks++;
        if (d !== 32'h0000_002C) begin n_fail++; $display("FAIL out_lane_gate got=%h exp=%h", d, 32'h2C); end
        bus_read(4'h3, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL set_reads_zero got=%h exp=0", d); end
    endtask

    task automatic test_dir_mask();
        logic [31:0] d, d12;
        bus_write(4'h1, 32'hFFFF_FFFF, 4'b0001);
        bus_read(4'h1, d, d12);
        n_checks++;
        if (d12 !== 32'h0000_00FF) begin n_fail++; $display("FAIL dir12_mask got=%h exp=%h", d12, 32'hFF); end
        n_checks++;
        if (oe12 !== 12'h0FF) begin n_fail++; $display("FAIL oe12 got=%h exp=0ff", oe12); end
        bus_write(4'h1, 32'hFFFF_FFFF, 4'b0010);
        bus_read(4'h1, d, d12);
        n_checks++;
        if (d12 !== 32'h0000_0FFF) begin n_fail++; $display("FAIL dir12_hi got=%h exp=%h", d12, 32'hFFF); end
        bus_write(4'h1, 32'h0, 4'b1111);
    endtask

    task automatic test_rise_irq();
        logic [31:0] d, d12;
        bus_write(4'h6, 32'h0000_0001, 4'b0001);
        pins_in = 8'h01;
        tick();
        bus_read(4'h2, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL in_edge1 got=%h exp=0", d); end
        tick();
        bus_read(4'h2, d, d12);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL in_edge2 got=%h exp=1", d); end
        n_checks++;
        if (irq8 !== 1'b0) begin n_fail++; $display("FAIL irq_edge2 got=%b exp=0", irq8); end
        tick();
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL pend_edge3 got=%h exp=1", d); end
        n_checks++;
        if (irq8 !== 1'b1) begin n_fail++; $display("FAIL irq_edge3 got=%b exp=1", irq8); end
        pins_in = 8'h00;
        repeat (4) tick();
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h1 || d !== m_read(4'h8)) begin
            n_fail++; $display("FAIL fall_masked got=%h exp=%h", d, 32'h1);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d, d12;
        pins_in = 8'h01;
        tick();
        tick();
        bus_write(4'h8, 32'h0000_0001, 4'b0001);
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_vs_set got=%h exp=1", d); end
        bus_write(4'h8, 32'h0000_0001, 4'b0001);
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got=%h exp=0", d); end
        n_checks++;
        if (irq8 !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got=%b exp=0", irq8); end
    endtask

    task automatic test_random();
        logic [31:0] d, d12, addr, exp;
        logic [3:0]  off;
        for (int it = 0; it < 250; it++) begin
            pins_in = 8'($urandom());
            if ($urandom_range(0, 3) != 0) begin
                addr = $urandom();
                addr[5:2] = 4'($urandom_range(0, 10));
                address_in     = addr;
                sel_in         = ($urandom_range(0, 7) != 0);
                write_mask_in  = 4'($urandom());
                write_value_in = $urandom();
            end
            $display("rnd it=%0d pins=%h sel=%b off=%h val=%h mask=%b",
                     it, pins_in, sel_in, address_in[5:2], write_value_in, write_mask_in);
            tick();
            sel_in = 1'b0;
            write_mask_in = '0;
            off = 4'($urandom_range(0, 10));
            bus_read(off, d, d12);
            exp = m_read(off);
            n_checks++;
            if (d !== exp) begin n_fail++; $display("FAIL rnd_read it=%0d off=%h got=%h exp=%h", it, off, d, exp); end
            n_checks++;
            if (irq8 !== (|m_pend)) begin n_fail++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, irq8, |m_pend); end
            n_checks++;
            if (out8 !== m_out || oe8 !== m_dir) begin
                n_fail++; $display("FAIL rnd_pins it=%0d out=%h oe=%h exp out=%h oe=%h", it, out8, oe8, m_out, m_dir);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, d12;
        pins_in = 8'h00;
        repeat (4) tick();
        bus_write(4'h6, 32'h0000_00FF, 4'b0001);
        bus_write(4'h7, 32'h0000_00FF, 4'b0001);
        bus_write(4'h8, 32'h0000_00FF, 4'b0001);
        pins_in = 8'hFF;
        repeat (4) tick();
        bus_write(4'h0, 32'h0000_0055, 4'b0001);
        bus_write(4'h1, 32'h0000_00F0, 4'b0001);
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'hFF) begin n_fail++; $display("FAIL pre_reset_pend got=%h exp=ff", d); end
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        n_checks++;
        if (out8 !== OUT_R || oe8 !== 8'h00 || irq8 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_pins out=%h oe=%h irq=%b exp out=%h oe=00 irq=0", out8, oe8, irq8, OUT_R);
        end
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL async_reset_pend got=%h exp=0", d); end
        bus_read(4'h6, d, d12);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL async_reset_rise got=%h exp=0", d); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Pins are still high: first rise after reset is masked by the cleared enables.
        repeat (SYNC + 2) tick();
        bus_read(4'h8, d, d12);
        n_checks++;
        if (d !== 32'h0 || irq8 !== 1'b0) begin n_fail++; $display("FAIL post_reset_masked got=%h irq=%b exp=0", d, irq8); end
        bus_read(4'h2, d, d12);
        n_checks++;
        if (d !== 32'hFF) begin n_fail++; $display("FAIL post_reset_in got=%h exp=ff", d); end
    endtask

    initial begin
        test_reset();
        test_set_clr_tgl();
        test_dir_mask();
        test_rise_irq();
        test_w1c_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
